// File: rtl/icache_linefill_ctrl.sv
// Linefill response collector: tracks issued linefill requests, assembles returning
// read-data beats into full lines, writes them to the data RAM and pulses per-entry done.
module icache_linefill_ctrl #(
  parameter int MSHR_ENTRY_NUM = 8,
  parameter int WAY_NUM        = 4,
  parameter int INDEX_W        = 8,
  parameter int BEAT_W         = 256,
  parameter int BEATS          = 2,
  localparam int ID_W          = $clog2(MSHR_ENTRY_NUM),
  localparam int LINE_W        = BEAT_W * BEATS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      txreq_fire,
  input  logic [ID_W-1:0]           txreq_entry_id,
  input  logic                      txreq_lineA,
  input  logic [INDEX_W-1:0]        txreq_index,
  input  logic [WAY_NUM-1:0]        txreq_way,
  input  logic                      rxdat_vld,
  output logic                      rxdat_rdy,
  input  logic [ID_W-1:0]           rxdat_entry_id,
  input  logic                      rxdat_lineA,
  input  logic [BEAT_W-1:0]         rxdat_data,
  output logic                      dataram_wr_vld,
  input  logic                      dataram_wr_rdy,
  output logic [INDEX_W-1:0]        dataram_wr_index,
  output logic [WAY_NUM-1:0]        dataram_wr_way,
  output logic [LINE_W-1:0]         dataram_wr_data,
  output logic [MSHR_ENTRY_NUM-1:0] linefillA_done,
  output logic [MSHR_ENTRY_NUM-1:0] linefillB_done,
  output logic                      proto_err
);

  localparam int SLOT_NUM = 2 * MSHR_ENTRY_NUM;
  localparam int SLOT_W   = ID_W + 1;
  localparam int CNT_W    = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [MSHR_ENTRY_NUM-1:0] ONE_HOT0 = {{(MSHR_ENTRY_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic                      beat_acc_s;
  logic                      wr_fire_s;
  logic                      err_s;

  logic [SLOT_NUM-1:0]       slot_vld_r;
  logic [INDEX_W-1:0]        slot_index_r [SLOT_NUM];
  logic [WAY_NUM-1:0]        slot_way_r   [SLOT_NUM];

  logic [CNT_W-1:0]          beat_cnt_r;
  logic [ID_W-1:0]           lat_id_r;
  logic                      lat_a_r;
  logic [LINE_W-1:0]         line_r;
  logic [INDEX_W-1:0]        wr_index_r;
  logic [WAY_NUM-1:0]        wr_way_r;
  logic                      wr_vld_r;
  logic                      rxdat_rdy_r;
  logic [MSHR_ENTRY_NUM-1:0] done_a_r;
  logic [MSHR_ENTRY_NUM-1:0] done_b_r;
  logic                      proto_err_r;

  logic [SLOT_W-1:0]         tx_slot_s;
  logic [SLOT_W-1:0]         rx_slot_s;
  logic [SLOT_W-1:0]         lat_slot_s;

  assign tx_slot_s  = {txreq_entry_id, txreq_lineA};
  assign rx_slot_s  = {rxdat_entry_id, rxdat_lineA};
  assign lat_slot_s = {lat_id_r, lat_a_r};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, beat acceptance, write handshake and protocol checks
  always_comb begin
    state_nxt_s = state_r;
    beat_acc_s  = 1'b0;
    wr_fire_s   = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (rxdat_vld && rxdat_rdy_r) begin
          beat_acc_s  = 1'b1;
          err_s       = !slot_vld_r[rx_slot_s];
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (rxdat_vld && rxdat_rdy_r) begin
          beat_acc_s = 1'b1;
          err_s      = (rxdat_entry_id != lat_id_r) || (rxdat_lineA != lat_a_r);
          if (beat_cnt_r == LAST_BEAT) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      WRITE: begin
        if (dataram_wr_rdy) begin
          wr_fire_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request table: a new request overrides the clear of the line being written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_r <= {SLOT_NUM{1'b0}};
      for (int i = 0; i < SLOT_NUM; i++) begin
        slot_index_r[i] <= {INDEX_W{1'b0}};
        slot_way_r[i]   <= {WAY_NUM{1'b0}};
      end
    end else begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        if (txreq_fire && (tx_slot_s == SLOT_W'(i))) begin
          slot_vld_r[i]   <= 1'b1;
          slot_index_r[i] <= txreq_index;
          slot_way_r[i]   <= txreq_way;
        end else if (wr_fire_s && (lat_slot_s == SLOT_W'(i))) begin
          slot_vld_r[i] <= 1'b0;
        end
      end
    end
  end

  // Line assembly and registered output datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r  <= {CNT_W{1'b0}};
      lat_id_r    <= {ID_W{1'b0}};
      lat_a_r     <= 1'b0;
      line_r      <= {LINE_W{1'b0}};
      wr_index_r  <= {INDEX_W{1'b0}};
      wr_way_r    <= {WAY_NUM{1'b0}};
      wr_vld_r    <= 1'b0;
      rxdat_rdy_r <= 1'b1;
      done_a_r    <= {MSHR_ENTRY_NUM{1'b0}};
      done_b_r    <= {MSHR_ENTRY_NUM{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      if (beat_acc_s) begin
        // Counter wraps back to 0 on the last beat since BEATS is a power of 2
        line_r[int'(beat_cnt_r)*BEAT_W +: BEAT_W] <= rxdat_data;
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
      if (beat_acc_s && (state_r == IDLE)) begin
        lat_id_r <= rxdat_entry_id;
        lat_a_r  <= rxdat_lineA;
      end
      if ((state_r == COLLECT) && (state_nxt_s == WRITE)) begin
        wr_index_r <= slot_index_r[lat_slot_s];
        wr_way_r   <= slot_way_r[lat_slot_s];
      end
      wr_vld_r    <= (state_nxt_s == WRITE);
      rxdat_rdy_r <= (state_nxt_s != WRITE);
      done_a_r    <= (wr_fire_s && lat_a_r)  ? (ONE_HOT0 << lat_id_r) : {MSHR_ENTRY_NUM{1'b0}};
      done_b_r    <= (wr_fire_s && !lat_a_r) ? (ONE_HOT0 << lat_id_r) : {MSHR_ENTRY_NUM{1'b0}};
      proto_err_r <= proto_err_r | err_s;
    end
  end

  assign rxdat_rdy        = rxdat_rdy_r;
  assign dataram_wr_vld   = wr_vld_r;
  assign dataram_wr_index = wr_index_r;
  assign dataram_wr_way   = wr_way_r;
  assign dataram_wr_data  = line_r;
  assign linefillA_done   = done_a_r;
  assign linefillB_done   = done_b_r;
  assign proto_err        = proto_err_r;

endmodule
